// File: rtl/user_settings_master.sv
// user_settings_master: queues user (addr, data) writes and serializes each one onto the
// settings bus as an address strobe to BASE followed by a data strobe to BASE+1.
module user_settings_master #(
    parameter int unsigned BASE        = 0,
    parameter int unsigned FIFO_AWIDTH = 2,
    parameter int unsigned GAP         = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_addr,
    input  logic [31:0]            in_data,
    output logic                   set_stb,
    output logic [7:0]             set_addr,
    output logic [31:0]            set_data,
    output logic [FIFO_AWIDTH:0]   fifo_level,
    output logic                   busy
);

    localparam int unsigned DEPTH = 1 << FIFO_AWIDTH;
    localparam int unsigned LW    = FIFO_AWIDTH + 1;

    localparam logic [7:0]    ADDR_REG   = 8'(BASE);
    localparam logic [7:0]    DATA_REG   = 8'(BASE + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [3:0]    GAP_LAST   = 4'(GAP - 1);
    localparam logic          GAP_EN     = (GAP != 0);

    // BASE+1 must not wrap onto the address register
    if (BASE == 255) begin : g_base_chk
        $error("user_settings_master: BASE=255 is illegal");
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    entry_t                 mem [DEPTH];
    logic [FIFO_AWIDTH-1:0] wr_ptr;
    logic [FIFO_AWIDTH-1:0] rd_ptr;
    logic [LW-1:0]          level;
    logic [LW-1:0]          level_next;
    logic                   push;
    logic                   pop_c;

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             gap_cnt;
    logic [3:0]             gap_cnt_next;
    entry_t                 hold;

    logic                   stb_d;
    logic [7:0]             addr_d;
    logic [31:0]            data_d;

    assign push       = in_valid & in_ready;
    assign level_next = level + LW'(push) - LW'(pop_c);
    assign fifo_level = level;

    // Queue storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: in_addr, data: in_data};
        end
    end

    // Queue pointers, level and the ready flag (kept equal to !full of the level register)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AWIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_AWIDTH'(1);
            end
            level    <= level_next;
            in_ready <= (level_next != FULL_LEVEL);
        end
    end

    // FSM state, gap counter and the popped entry being serialized
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
            hold    <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
            if (pop_c) begin
                hold <= mem[rd_ptr];
            end
        end
    end

    // Next-state and next-output decode; bus address/data hold while idle
    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        pop_c        = 1'b0;
        stb_d        = 1'b0;
        addr_d       = set_addr;
        data_d       = set_data;
        unique case (state)
            S_IDLE: begin
                if (level != '0) begin
                    pop_c      = 1'b1;
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                stb_d      = 1'b1;
                addr_d     = ADDR_REG;
                data_d     = {24'h0, hold.addr};
                state_next = S_DATA;
            end
            S_DATA: begin
                stb_d  = 1'b1;
                addr_d = DATA_REG;
                data_d = hold.data;
                if (GAP_EN) begin
                    gap_cnt_next = '0;
                    state_next   = S_GAP;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Registered bus outputs and activity flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_stb  <= 1'b0;
            set_addr <= '0;
            set_data <= '0;
            busy     <= 1'b0;
        end else begin
            set_stb  <= stb_d;
            set_addr <= addr_d;
            set_data <= data_d;
            busy     <= (state != S_IDLE) || (state_next != S_IDLE) || (level_next != '0);
        end
    end

endmodule

// File: tb/tb_user_settings_master.sv
// Self-checking bench for user_settings_master: directed vector table, back-to-back and
// gap sequences, mid-operation reset, and a loopback through a behavioural decoder model.
module tb_user_settings_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic [7:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [2:0]  fifo_level;
    logic        busy;

    logic        g_in_valid = 1'b0;
    logic [7:0]  g_in_addr = '0;
    logic [31:0] g_in_data = '0;
    logic        g_in_ready;
    logic        g_set_stb;
    logic [7:0]  g_set_addr;
    logic [31:0] g_set_data;
    logic [2:0]  g_fifo_level;
    logic        g_busy;

    always #5 clk = ~clk;

    user_settings_master #(.BASE(8), .FIFO_AWIDTH(2), .GAP(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .fifo_level(fifo_level), .busy(busy)
    );

    user_settings_master #(.BASE(48), .FIFO_AWIDTH(2), .GAP(2)) u_gap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(g_in_valid), .in_ready(g_in_ready), .in_addr(g_in_addr), .in_data(g_in_data),
        .set_stb(g_set_stb), .set_addr(g_set_addr), .set_data(g_set_data),
        .fifo_level(g_fifo_level), .busy(g_busy)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } stb_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
    } vec_t;

    stb_t       log_q[$];
    stb_t       glog_q[$];
    wr_t        user_q[$];
    wr_t        exp_q[$];
    logic [7:0] dec_addr = '0;
    int         cyc = 0;
    int         ready_bad = 0;
    int         saw_full = 0;
    int         tests = 0;
    int         failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe logger, decoder model (BASE=8) and queue-flag watcher
    always @(negedge clk) begin
        if (set_stb) begin
            log_q.push_back('{cyc, set_addr, set_data});
            if (set_addr == 8'd8) dec_addr = set_data[7:0];
            else if (set_addr == 8'd9) user_q.push_back('{dec_addr, set_data});
        end
        if (g_set_stb) glog_q.push_back('{cyc, g_set_addr, g_set_data});
        if (rst_n) begin
            if (in_ready != (fifo_level != 3'd4)) ready_bad++;
            if (fifo_level == 3'd4 && !in_ready) saw_full = 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_item(input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || fifo_level != 3'd0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle"}, {62'h0, busy, (fifo_level != 3'd0)}, 64'h0);
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{8'h12, 32'hDEADBEEF, 32'h00000012, 32'hDEADBEEF};
        vecs[1] = '{8'hFF, 32'h00000000, 32'h000000FF, 32'h00000000};
        vecs[2] = '{8'h00, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};

        // Reset state
        @(negedge clk);
        check("reset bus", {23'h0, set_stb, set_addr, set_data}, 64'h0);
        check("reset flags", {59'h0, fifo_level, in_ready, busy}, {59'h0, 3'd0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Single writes: latency and held outputs
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_addr  = vecs[i].addr;
            in_data  = vecs[i].data;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d N level", i), {60'h0, set_stb, fifo_level}, {60'h0, 1'b0, 3'd1});
            @(negedge clk);
            check($sformatf("v%0d N+1 stb", i), {63'h0, set_stb}, 64'h0);
            @(negedge clk);
            check($sformatf("v%0d N+2 addr strobe", i), {23'h0, set_stb, set_addr, set_data},
                  {23'h0, 1'b1, 8'd8, vecs[i].exp_a});
            @(negedge clk);
            check($sformatf("v%0d N+3 data strobe", i), {22'h0, busy, set_stb, set_addr, set_data},
                  {22'h0, 1'b1, 1'b1, 8'd9, vecs[i].exp_d});
            @(negedge clk);
            check($sformatf("v%0d N+4 idle hold", i), {22'h0, busy, set_stb, set_addr, set_data},
                  {22'h0, 1'b0, 1'b0, 8'd9, vecs[i].exp_d});
        end

        // Six back-to-back writes through a 4-deep queue
        log_q.delete();
        ready_bad = 0;
        saw_full = 0;
        for (int i = 0; i < 6; i++) push_item(8'(8'h40 + i), 32'hA000_0000 + 32'(i));
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle("b2b");
        check("b2b strobe count", 64'(log_q.size()), 64'd12);
        for (int j = 0; j < 6 && log_q.size() == 12; j++) begin
            check($sformatf("b2b addr strobe %0d", j), {log_q[2*j].addr, log_q[2*j].data},
                  {8'd8, 24'h0, 8'(8'h40 + j)});
            check($sformatf("b2b data strobe %0d", j), {log_q[2*j+1].addr, log_q[2*j+1].data},
                  {8'd9, 32'hA000_0000 + 32'(j)});
            check($sformatf("b2b adjacent %0d", j), 64'(log_q[2*j+1].cyc - log_q[2*j].cyc), 64'd1);
            if (j < 5)
                check($sformatf("b2b spacing %0d", j), 64'(log_q[2*j+2].cyc - log_q[2*j+1].cyc), 64'd2);
        end
        check("b2b full seen", 64'(saw_full), 64'd1);
        check("ready tracks full", 64'(ready_bad), 64'd0);

        // GAP=2: three quiet cycles between pairs
        glog_q.delete();
        @(negedge clk);
        g_in_valid = 1'b1;
        g_in_addr  = 8'h21;
        g_in_data  = 32'h0000_0001;
        @(negedge clk);
        g_in_addr  = 8'h22;
        g_in_data  = 32'h0000_0002;
        @(negedge clk);
        g_in_valid = 1'b0;
        for (int n = 0; n < 100 && (g_busy || g_fifo_level != 3'd0); n++) @(negedge clk);
        check("gap strobe count", 64'(glog_q.size()), 64'd4);
        if (glog_q.size() == 4) begin
            check("gap first data", {glog_q[1].addr, glog_q[1].data}, {8'h31, 32'h1});
            check("gap second addr", {glog_q[2].addr, glog_q[2].data}, {8'h30, 32'h22});
            check("gap pair adjacent", 64'(glog_q[1].cyc - glog_q[0].cyc), 64'd1);
            check("gap spacing", 64'(glog_q[2].cyc - glog_q[1].cyc), 64'd4);
        end

        // Reset right after an ADDR strobe with three entries queued
        for (int i = 0; i < 5; i++) push_item(8'(8'h50 + i), 32'hB000_0000 + 32'(i));
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 50 && !(set_stb && set_addr == 8'd8 && set_data == 32'h51); n++)
            @(negedge clk);
        check("rst pre addr strobe", {set_stb, set_data}, {1'b1, 32'h51});
        check("rst pre level", 64'(fifo_level), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        log_q.delete();
        check("rst async bus", {23'h0, set_stb, set_addr, set_data}, 64'h0);
        check("rst async flags", {59'h0, fifo_level, in_ready, busy}, {59'h0, 3'd0, 1'b1, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst no strobes", 64'(log_q.size()), 64'd0);
        check("rst stays empty", {62'h0, busy, (fifo_level != 3'd0)}, 64'h0);

        // Loopback through the decoder model, 100 writes with repeated addresses
        user_q.delete();
        exp_q.delete();
        ready_bad = 0;
        for (int i = 0; i < 100; i++) begin
            logic [7:0]  a;
            logic [31:0] d;
            a = 8'($urandom_range(0, 7));
            d = $urandom;
            if (i == 11) begin
                a = exp_q[10].addr;
                d = exp_q[10].data;
            end
            push_item(a, d);
            exp_q.push_back('{a, d});
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle("loopback");
        check("loopback count", 64'(user_q.size()), 64'd100);
        for (int i = 0; i < 100 && i < user_q.size(); i++)
            check($sformatf("loopback %0d", i), {user_q[i].addr, user_q[i].data},
                  {exp_q[i].addr, exp_q[i].data});
        check("loopback ready", 64'(ready_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
